// File: rtl/cmp_pkg.sv
// Shared types and helpers for the comparator: the three-way result enum
// and a saturating increment used by the result-event counters.
package cmp_pkg;

   typedef enum logic [1:0] {
      CMP_LT = 2'd0,
      CMP_EQ = 2'd1,
      CMP_GT = 2'd2
   } cmp_res_e;

   // Increment cnt by one, sticking at max_val instead of wrapping.
   // Operates on 32-bit values so any counter width up to 32 can use it.
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                           input logic [31:0] max_val);
      logic [31:0] nxt;
      if (cnt >= max_val) begin
         nxt = max_val;
      end else begin
         nxt = cnt + 32'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/cmp_core.sv
// Purely combinational three-way compare of two WIDTH-bit operands.
// With SIGNED=1 the MSB is treated as a two's-complement sign bit.
module cmp_core
   import cmp_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int SIGNED = 0
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output cmp_res_e         res
);

   // Extend both operands by one bit (sign- or zero-extension) so a single
   // signed comparison covers both the unsigned and the signed modes.
   logic signed [WIDTH:0] a_ext;
   logic signed [WIDTH:0] b_ext;

   // Build the extended operands according to the compare mode.
   always_comb begin
      a_ext = '0;
      b_ext = '0;
      if (SIGNED != 0) begin
         a_ext = {A[WIDTH-1], A};
         b_ext = {B[WIDTH-1], B};
      end else begin
         a_ext = {1'b0, A};
         b_ext = {1'b0, B};
      end
   end

   // Resolve the ordering into exactly one of the three result codes.
   always_comb begin
      res = CMP_EQ;
      if (a_ext > b_ext) begin
         res = CMP_GT;
      end else if (a_ext < b_ext) begin
         res = CMP_LT;
      end else begin
         res = CMP_EQ;
      end
   end

endmodule

// File: rtl/comparator_behave.sv
// Registered comparator: samples A/B when in_valid is high, presents a
// one-hot gt/lt/et result one cycle later and keeps saturating counts of
// how many sampled pairs produced each result.
module comparator_behave
   import cmp_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int SIGNED = 0,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             in_valid,
   input  logic             clr_cnt,
   output logic             gt,
   output logic             lt,
   output logic             et,
   output logic             out_valid,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] et_cnt
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   cmp_res_e res;

   cmp_core #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_core (
      .A   (A),
      .B   (B),
      .res (res)
   );

   // Result register: capture the compare on a valid pair, otherwise hold
   // the last result and drop out_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gt        <= 1'b0;
         lt        <= 1'b0;
         et        <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         gt        <= (res == CMP_GT);
         lt        <= (res == CMP_LT);
         et        <= (res == CMP_EQ);
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

   // Event counters: clear wins over a same-edge increment; increments saturate.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gt_cnt <= '0;
         lt_cnt <= '0;
         et_cnt <= '0;
      end else if (clr_cnt) begin
         gt_cnt <= '0;
         lt_cnt <= '0;
         et_cnt <= '0;
      end else if (in_valid) begin
         case (res)
            CMP_GT:  gt_cnt <= CNT_W'(sat_inc(32'(gt_cnt), CNT_MAX));
            CMP_LT:  lt_cnt <= CNT_W'(sat_inc(32'(lt_cnt), CNT_MAX));
            CMP_EQ:  et_cnt <= CNT_W'(sat_inc(32'(et_cnt), CNT_MAX));
            default: et_cnt <= et_cnt;
         endcase
      end else begin
         gt_cnt <= gt_cnt;
      end
   end

endmodule

// File: tb/tb_comparator_behave.sv
// Self-checking bench for comparator_behave. Three instances share one
// stimulus stream: unsigned/16-bit counters, signed/16-bit counters and
// unsigned/2-bit counters. An integer-arithmetic model predicts every
// output of every instance; literal expectations pin the directed cases.
module tb_comparator_behave;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] a = 2'd0;
   logic [1:0] b = 2'd0;
   logic       in_valid = 1'b0;
   logic       clr_cnt = 1'b0;

   logic        gt0, lt0, et0, ov0;
   logic [15:0] gc0, lc0, ec0;
   logic        gt1, lt1, et1, ov1;
   logic [15:0] gc1, lc1, ec1;
   logic        gt2, lt2, et2, ov2;
   logic [1:0]  gc2, lc2, ec2;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model state per instance k: 0 unsigned, 1 signed, 2 unsigned small counters
   int m_gt[3], m_lt[3], m_et[3], m_ov[3];
   int m_gc[3], m_lc[3], m_ec[3];
   int is_signed[3] = '{0, 1, 0};
   int cmax[3]      = '{65535, 65535, 3};

   always #5 clk = ~clk;

   comparator_behave #(.WIDTH(2), .SIGNED(0), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid), .clr_cnt(clr_cnt),
      .gt(gt0), .lt(lt0), .et(et0), .out_valid(ov0),
      .gt_cnt(gc0), .lt_cnt(lc0), .et_cnt(ec0));

   comparator_behave #(.WIDTH(2), .SIGNED(1), .CNT_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid), .clr_cnt(clr_cnt),
      .gt(gt1), .lt(lt1), .et(et1), .out_valid(ov1),
      .gt_cnt(gc1), .lt_cnt(lc1), .et_cnt(ec1));

   comparator_behave #(.WIDTH(2), .SIGNED(0), .CNT_W(2)) u2 (
      .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid), .clr_cnt(clr_cnt),
      .gt(gt2), .lt(lt2), .et(et2), .out_valid(ov2),
      .gt_cnt(gc2), .lt_cnt(lc2), .et_cnt(ec2));

   function automatic int to_val(input int raw, input int sgn);
      if (sgn != 0 && raw >= 2) return raw - 4;
      return raw;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, advanced on every rising edge from the sampled inputs.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         int va, vb;
         va = to_val(int'(a), is_signed[k]);
         vb = to_val(int'(b), is_signed[k]);
         if (!rst_n) begin
            m_gt[k] <= 0; m_lt[k] <= 0; m_et[k] <= 0; m_ov[k] <= 0;
            m_gc[k] <= 0; m_lc[k] <= 0; m_ec[k] <= 0;
         end else begin
            if (in_valid) begin
               m_gt[k] <= (va > vb)  ? 1 : 0;
               m_lt[k] <= (va < vb)  ? 1 : 0;
               m_et[k] <= (va == vb) ? 1 : 0;
               m_ov[k] <= 1;
            end else begin
               m_ov[k] <= 0;
            end
            if (clr_cnt) begin
               m_gc[k] <= 0; m_lc[k] <= 0; m_ec[k] <= 0;
            end else if (in_valid) begin
               if (va > vb)  m_gc[k] <= (m_gc[k] < cmax[k]) ? m_gc[k] + 1 : cmax[k];
               if (va < vb)  m_lc[k] <= (m_lc[k] < cmax[k]) ? m_lc[k] + 1 : cmax[k];
               if (va == vb) m_ec[k] <= (m_ec[k] < cmax[k]) ? m_ec[k] + 1 : cmax[k];
            end
         end
      end
   end

   // Compare every output of every instance against the model each cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("u0.gt", int'(gt0), m_gt[0]); check("u0.lt", int'(lt0), m_lt[0]);
         check("u0.et", int'(et0), m_et[0]); check("u0.ov", int'(ov0), m_ov[0]);
         check("u0.gc", int'(gc0), m_gc[0]); check("u0.lc", int'(lc0), m_lc[0]);
         check("u0.ec", int'(ec0), m_ec[0]);
         check("u1.gt", int'(gt1), m_gt[1]); check("u1.lt", int'(lt1), m_lt[1]);
         check("u1.et", int'(et1), m_et[1]); check("u1.ov", int'(ov1), m_ov[1]);
         check("u1.gc", int'(gc1), m_gc[1]); check("u1.lc", int'(lc1), m_lc[1]);
         check("u1.ec", int'(ec1), m_ec[1]);
         check("u2.gt", int'(gt2), m_gt[2]); check("u2.lt", int'(lt2), m_lt[2]);
         check("u2.et", int'(et2), m_et[2]); check("u2.ov", int'(ov2), m_ov[2]);
         check("u2.gc", int'(gc2), m_gc[2]); check("u2.lc", int'(lc2), m_lc[2]);
         check("u2.ec", int'(ec2), m_ec[2]);
         if (ov0) check("u0.onehot", int'(gt0) + int'(lt0) + int'(et0), 1);
      end
   end

   // Apply one set of inputs, then wait until just after the edge that samples them.
   task automatic cyc(input int ai, input int bi, input bit v, input bit c, input bit r);
      a = 2'(ai); b = 2'(bi); in_valid = v; clr_cnt = c; rst_n = r;
      @(negedge clk);
      #1;
   endtask

   int dir_a[5]  = '{0, 1, 2, 3, 0};
   int dir_b[5]  = '{0, 0, 2, 1, 3};
   int dir_gt[5] = '{0, 1, 0, 1, 0};
   int dir_lt[5] = '{0, 0, 0, 0, 1};
   int dir_et[5] = '{1, 0, 1, 0, 0};

   initial begin
      // Reset state
      cyc(1, 0, 1'b1, 1'b0, 1'b0);
      cyc(1, 0, 1'b1, 1'b1, 1'b0);
      chk_en = 1'b1;
      check("rst.gt", int'(gt0), 0); check("rst.ov", int'(ov0), 0);
      check("rst.ec", int'(ec0), 0);

      // Directed sequence, each result checked one cycle later
      for (int i = 0; i < 5; i++) begin
         cyc(dir_a[i], dir_b[i], 1'b1, 1'b0, 1'b1);
         check($sformatf("dir%0d.gt", i), int'(gt0), dir_gt[i]);
         check($sformatf("dir%0d.lt", i), int'(lt0), dir_lt[i]);
         check($sformatf("dir%0d.et", i), int'(et0), dir_et[i]);
         check($sformatf("dir%0d.ov", i), int'(ov0), 1);
      end
      check("dir.gt_cnt", int'(gc0), 2);
      check("dir.et_cnt", int'(ec0), 2);
      check("dir.lt_cnt", int'(lc0), 1);

      // Signed operand cases
      cyc(3, 1, 1'b1, 1'b0, 1'b1);
      check("s.m1_lt_p1", int'(lt1), 1); check("u.3_gt_1", int'(gt0), 1);
      cyc(2, 3, 1'b1, 1'b0, 1'b1);
      check("s.m2_lt_m1", int'(lt1), 1); check("s.m2_gt", int'(gt1), 0);

      // Saturation of 2-bit counters
      cyc(0, 0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) cyc(i % 4, i % 4, 1'b1, 1'b0, 1'b1);
      check("sat.et_cnt", int'(ec2), 3);
      check("sat.et_cnt16", int'(ec0), 5);

      // Clear together with a valid pair
      cyc(1, 0, 1'b1, 1'b1, 1'b1);
      check("clr.gc", int'(gc0), 0); check("clr.ec", int'(ec0), 0);
      check("clr.gt", int'(gt0), 1); check("clr.ov", int'(ov0), 1);

      // Reset overriding a valid pair
      cyc(1, 0, 1'b1, 1'b0, 1'b0);
      check("rstv.gt", int'(gt0), 0); check("rstv.ov", int'(ov0), 0);
      check("rstv.ec", int'(ec0), 0);

      // Exhaustive sweep, then idle: result held and out_valid low
      for (int i = 0; i < 16; i++) cyc(i / 4, i % 4, 1'b1, 1'b0, 1'b1);
      cyc(0, 3, 1'b0, 1'b0, 1'b1);
      check("idle.ov", int'(ov0), 0); check("idle.et_held", int'(et0), 1);
      check("sweep.gc", int'(gc0), 6); check("sweep.lc", int'(lc0), 6);
      check("sweep.ec", int'(ec0), 4);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 49) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/comparator_behave.md
COMPARATOR_BEHAVE -- requirements
Module: comparator_behave

Interface
REQ-001 Parameter WIDTH, default 2: operand width in bits; legal range 1..32.
REQ-002 Parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 Parameter CNT_W, default 16: width of each result-event counter.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 in_valid  input  1  A/B sampled on a rising edge when high.
REQ-010 clr_cnt  input  1  synchronous clear of the event counters.
REQ-011 gt  output  1  registered A > B.
REQ-012 lt  output  1  registered A < B.
REQ-013 et  output  1  registered A == B.
REQ-014 out_valid  output  1  gt/lt/et hold a result from a sampled operand pair.
REQ-015 gt_cnt, lt_cnt, et_cnt  output  CNT_W each  number of sampled pairs with each result.

Function
REQ-016 On a rising edge with rst_n=1 and in_valid=1, gt/lt/et SHALL be updated from the current A, B (one-cycle latency), and out_valid SHALL be set to 1.
REQ-017 With in_valid=0, gt/lt/et SHALL hold their previous values, and out_valid SHALL be 0 on the following cycle.
REQ-018 When out_valid=1, exactly one of gt, lt, et SHALL be 1.
REQ-019 With SIGNED=0, operands SHALL be compared as unsigned; with SIGNED=1, the MSB is the sign bit.
REQ-020 Each counter SHALL increment by 1 on every sampled pair whose result matches it.
REQ-021 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap around.
REQ-022 clr_cnt=1 SHALL zero all counters on that edge; it takes priority over a simultaneous increment.
REQ-023 clr_cnt SHALL NOT affect gt/lt/et or out_valid.
REQ-024 The comparison SHALL be purely combinational before the output register; no other pipeline stages are allowed.

Reset
REQ-025 With rst_n=0 at a rising edge, gt, lt, et, out_valid and all counters SHALL become 0, overriding in_valid and clr_cnt.
REQ-026 A reset asserted mid-stream SHALL discard the pair sampled on that edge.
REQ-027 After reset deasserts, the first in_valid=1 edge SHALL produce a valid result on the next cycle.

Structure
REQ-028 Shared package cmp_pkg SHALL hold the result enum (CMP_LT, CMP_EQ, CMP_GT) and the counter-saturation helper function.
REQ-029 The combinational compare SHALL be a sub-module cmp_core (parameters WIDTH and SIGNED; inputs A and B; output is the result enum).
REQ-030 Registers and counters SHALL reside in comparator_behave.

Verification (WIDTH=2, SIGNED=0 unless stated)
REQ-031 Directed sequence with in_valid=1, one pair per cycle, each checked one cycle later:
- A=00, B=00 -> et=1, gt=0, lt=0.
- A=01, B=00 -> gt=1.
- A=10, B=10 -> et=1.
- A=11, B=01 -> gt=1.
- A=00, B=11 -> lt=1.
After the sequence: gt_cnt=2, et_cnt=2, lt_cnt=1.
REQ-032 Exhaustive 16-pair sweep -> one-hot outputs match an arithmetic model; then in_valid=0 -> outputs held and out_valid=0.
REQ-033 SIGNED=1: A=11 (-1), B=01 (+1) -> lt=1.
REQ-034 SIGNED=1: A=10 (-2), B=11 (-1) -> lt=1.
REQ-035 Saturation with CNT_W=2: five consecutive A=B pairs -> et_cnt stays at 3.
REQ-036 Simultaneous clr_cnt=1 and in_valid=1 -> counters become 0 and outputs update.
REQ-037 rst_n=0 with in_valid=1 and A=01, B=00 -> all outputs 0 on the next cycle.
